// File: rtl/opload_pkg.sv
// Shared definitions for the matrix operand loader.
// Provides element/matrix sizing, the loader state type and the
// column-major B index remap used when OPLOAD_COLMAJOR_B_EN is defined.
package opload_pkg;

  localparam int unsigned ELEM_W    = 8;
  localparam int unsigned MAT_DIM   = 3;
  localparam int unsigned MAT_ELEMS = 9;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    LAUNCH,
    WAIT
  } state_e;

  // Stream position idx of a column-major stream lands in row idx%3,
  // column idx/3 of the row-major packed matrix.
  function automatic logic [3:0] colmajor_slot(input logic [3:0] idx);
    int unsigned i;
    i = 32'(idx);
    return 4'(MAT_DIM * (i % MAT_DIM) + i / MAT_DIM);
  endfunction

endpackage

// File: rtl/matrix_shadow_bank.sv
// One 3x3 operand bank: nine staging registers written one element at a
// time, plus a 72-bit output register loaded from staging on commit.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears everything)
//   wr_en     - write wr_data into staging slot wr_idx
//   wr_idx    - staging slot 0..8 (row-major position in mat_out)
//   wr_data   - element to stage
//   commit    - copy staging into mat_out
//   mat_out   - element k at bits [8k+7:8k]
module matrix_shadow_bank
  import opload_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [3:0]                    wr_idx,
  input  logic [ELEM_W-1:0]             wr_data,
  input  logic                          commit,
  output logic [MAT_ELEMS*ELEM_W-1:0]   mat_out
);

  logic [ELEM_W-1:0]           stage_q [MAT_ELEMS];
  logic [ELEM_W-1:0]           stage_d [MAT_ELEMS];
  logic [MAT_ELEMS*ELEM_W-1:0] mat_q;
  logic [MAT_ELEMS*ELEM_W-1:0] mat_d;

  // The commit coincides with the write of the final element, so the
  // output register is loaded from the post-write staging view.
  always_comb begin
    stage_d = stage_q;
    if (wr_en && (wr_idx < 4'(MAT_ELEMS))) begin
      stage_d[wr_idx] = wr_data;
    end
    mat_d = mat_q;
    if (commit) begin
      for (int unsigned i = 0; i < MAT_ELEMS; i++) begin
        mat_d[i*ELEM_W +: ELEM_W] = stage_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAT_ELEMS; i++) begin
        stage_q[i] <= '0;
      end
      mat_q <= '0;
    end else begin
      stage_q <= stage_d;
      mat_q   <= mat_d;
    end
  end

  assign mat_out = mat_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for the 3x3 systolic multiplier.
// Accepts 9 A then 9 B bytes (valid/ready), commits them to stable
// double-buffered a_mat/b_mat, strobes mm_start, holds for COMPUTE_CYCLES
// then strobes load_done and re-opens input.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_data/in_valid    - serial element stream
//   in_ready            - high in LOAD_A/LOAD_B (low while rst asserted)
//   a_mat, b_mat        - packed operands, element Arc at 8*(3r+c)
//   mm_start            - one-cycle strobe, operands newly valid
//   mm_busy             - high in LAUNCH and WAIT
//   load_done           - one-cycle strobe at end of compute window
// Optional: define OPLOAD_COLMAJOR_B_EN for a column-major B stream.
module matrix_operand_loader #(
  parameter int unsigned COMPUTE_CYCLES = 8,
  parameter int unsigned ELEM_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ELEM_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [9*ELEM_W-1:0]   a_mat,
  output logic [9*ELEM_W-1:0]   b_mat,
  output logic                  mm_start,
  output logic                  mm_busy,
  output logic                  load_done
);

  import opload_pkg::state_e;
  import opload_pkg::LOAD_A;
  import opload_pkg::LOAD_B;
  import opload_pkg::LAUNCH;
  import opload_pkg::WAIT;

  localparam logic [7:0] WAIT_INIT = 8'(COMPUTE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX  = 4'd8;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic       xfer;
  logic       a_wr;
  logic       b_wr;
  logic       commit;
  logic [3:0] b_slot;

  assign in_ready = ~rst & ((state_q == LOAD_A) | (state_q == LOAD_B));
  assign xfer     = in_valid & in_ready;
  assign a_wr     = xfer & (state_q == LOAD_A);
  assign b_wr     = xfer & (state_q == LOAD_B);
  assign commit   = b_wr & (idx_q == LAST_IDX);

`ifdef OPLOAD_COLMAJOR_B_EN
  assign b_slot = opload_pkg::colmajor_slot(idx_q);
`else
  assign b_slot = idx_q;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    mm_start  = 1'b0;
    mm_busy   = 1'b0;
    load_done = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LAUNCH;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      LAUNCH: begin
        mm_start = 1'b1;
        mm_busy  = 1'b1;
        wcnt_d   = WAIT_INIT;
        state_d  = WAIT;
      end
      WAIT: begin
        mm_busy = 1'b1;
        if (wcnt_q == '0) begin
          load_done = 1'b1;
          state_d   = LOAD_A;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  matrix_shadow_bank u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_wr),
    .wr_idx  (idx_q),
    .wr_data (in_data),
    .commit  (commit),
    .mat_out (a_mat)
  );

  matrix_shadow_bank u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_wr),
    .wr_idx  (b_slot),
    .wr_data (in_data),
    .commit  (commit),
    .mat_out (b_mat)
  );

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;

  localparam int unsigned CC = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] a_mat;
  logic [71:0] b_mat;
  logic        mm_start;
  logic        mm_busy;
  logic        load_done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [71:0] exp_a = '0;
  logic [71:0] exp_b = '0;
  logic [7:0]  stream [18];

  matrix_operand_loader #(.COMPUTE_CYCLES(CC), .ELEM_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mat     (a_mat),
    .b_mat     (b_mat),
    .mm_start  (mm_start),
    .mm_busy   (mm_busy),
    .load_done (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk72(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: A element k of the stream is matrix position k (row-major).
  function automatic logic [71:0] model_a();
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[8*i +: 8] = stream[i];
    return r;
  endfunction

  // Reference: B position i is row i/3, col i%3 (row-major stream) or
  // row i%3, col i/3 (column-major stream).
  function automatic logic [71:0] model_b();
    logic [71:0] r;
    int row, col;
    r = '0;
    for (int i = 0; i < 9; i++) begin
`ifdef OPLOAD_COLMAJOR_B_EN
      row = i % 3; col = i / 3;
`else
      row = i / 3; col = i % 3;
`endif
      r[8*(3*row+col) +: 8] = stream[9+i];
    end
    return r;
  endfunction

  // gap: 0 = valid every cycle, 1 = valid every other cycle, 2 = random.
  // nbytes < 18 stops after a partial load; abort_wait > 0 returns in WAIT.
  task automatic send_set(input int gap, input int nbytes, input int abort_wait);
    int  k;
    int  idle;
    int  c;
    bit  got;
    bit  v;
    k = 0; idle = 0; v = 1'b0;
    while (k < nbytes) begin
      @(negedge clk);
      chk1("in_ready_load", in_ready, 1'b1);
      chk1("busy_load", mm_busy, 1'b0);
      chk72("a_hold_load", a_mat, exp_a);
      chk72("b_hold_load", b_mat, exp_b);
      if (gap == 1)      v = ~v;
      else if (gap == 2) v = (idle >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      else               v = 1'b1;
      in_valid = v;
      in_data  = v ? stream[k] : 8'hFF;
      if (v) begin k++; idle = 0; end else idle++;
    end
    if (nbytes < 18) begin
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    exp_a = model_a();
    exp_b = model_b();
    chk1("mm_start", mm_start, 1'b1);
    chk1("busy_launch", mm_busy, 1'b1);
    chk1("ready_launch", in_ready, 1'b0);
    chk1("done_launch", load_done, 1'b0);
    chk72("a_mat", a_mat, exp_a);
    chk72("b_mat", b_mat, exp_b);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    c = 0; got = 1'b0;
    while (!got && c < 300) begin
      @(negedge clk);
      c++;
      if (abort_wait > 0 && c == abort_wait) return;
      chk1("start_wait", mm_start, 1'b0);
      chk1("busy_wait", mm_busy, 1'b1);
      chk1("ready_wait", in_ready, 1'b0);
      chk72("a_hold_wait", a_mat, exp_a);
      if (load_done) got = 1'b1;
    end
    chkint("done_latency", c, int'(CC));
    @(negedge clk);
    chk1("ready_after", in_ready, 1'b1);
    chk1("busy_after", mm_busy, 1'b0);
    chk1("done_once", load_done, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_a = '0;
    exp_b = '0;
    chk72("rst_a", a_mat, exp_a);
    chk72("rst_b", b_mat, exp_b);
    chk1("rst_start", mm_start, 1'b0);
    chk1("rst_busy", mm_busy, 1'b0);
    chk1("rst_done", load_done, 1'b0);
    chk1("rst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 18; i++) stream[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    #3;
    chk72("rst0_a", a_mat, 72'h0);
    chk72("rst0_b", b_mat, 72'h0);
    chk1("rst0_ready", in_ready, 1'b0);
    chk1("rst0_start", mm_start, 1'b0);
    chk1("rst0_busy", mm_busy, 1'b0);
    chk1("rst0_done", load_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stream 0x01..0x12 back to back, then with alternating valid.
    for (int i = 0; i < 18; i++) stream[i] = 8'(i + 1);
    for (int pass = 0; pass < 2; pass++) begin
      send_set(pass, 18, 0);
      chk72("const_a", a_mat, 72'h090807060504030201);
`ifdef OPLOAD_COLMAJOR_B_EN
      chk72("const_b", b_mat, 72'h120F0C110E0B100D0A);
`else
      chk72("const_b", b_mat, 72'h1211100F0E0D0C0B0A);
`endif
    end

    // Double buffering: set 1 all 0x3C stays visible while set 2 loads.
    for (int i = 0; i < 18; i++) stream[i] = 8'h3C;
    send_set(0, 18, 0);
    chk72("dbuf_a1", a_mat, {9{8'h3C}});
    for (int i = 0; i < 18; i++) stream[i] = 8'(8'h44 + i);
    send_set(2, 18, 0);

    for (int n = 0; n < 3; n++) begin
      fill_random();
      send_set(2, 18, 0);
    end

    // Reset after 5 A bytes, then a full set.
    fill_random();
    send_set(2, 5, 0);
    do_reset();
    fill_random();
    send_set(2, 18, 0);

    // Reset during WAIT, then a full set.
    fill_random();
    send_set(0, 18, 3);
    do_reset();
    fill_random();
    send_set(1, 18, 0);

    // Directed B stream 0x10..0x18.
    for (int i = 0; i < 9; i++) stream[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) stream[9+i] = 8'(8'h10 + i);
    send_set(0, 18, 0);
`ifdef OPLOAD_COLMAJOR_B_EN
    chk8("b01", b_mat[15:8], 8'h13);
    chk8("b02", b_mat[23:16], 8'h16);
    chk8("b10", b_mat[31:24], 8'h11);
`else
    chk8("b01", b_mat[15:8], 8'h11);
    chk8("b02", b_mat[23:16], 8'h12);
    chk8("b10", b_mat[31:24], 8'h13);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
